// File: rtl/router_ctrl_if.sv
// rtl/router_ctrl_if.sv - source, FIFO and strobe signals of the 1x3 router control block
interface router_ctrl_if;
   logic       packet_valid;
   logic [1:0] addr_in;
   logic [2:0] fifo_full;
   logic [2:0] fifo_empty;
   logic [2:0] read_enb;
   logic       parity_done;
   logic       low_packet_valid;
   logic [2:0] vld_out;
   logic [2:0] soft_reset;
   logic [2:0] write_enb;
   logic       sel_full;
   logic       busy;
   logic       detect_add;
   logic       lfd_state;
   logic       ld_state;
   logic       laf_state;
   logic       full_state;
   logic       lp_state;
   logic       rst_int_reg;
   logic       write_enb_reg;

   modport master (
      output packet_valid, addr_in, fifo_full, fifo_empty, read_enb,
             parity_done, low_packet_valid,
      input  vld_out, soft_reset, write_enb, sel_full, busy, detect_add,
             lfd_state, ld_state, laf_state, full_state, lp_state,
             rst_int_reg, write_enb_reg
   );

   modport slave (
      input  packet_valid, addr_in, fifo_full, fifo_empty, read_enb,
             parity_done, low_packet_valid,
      output vld_out, soft_reset, write_enb, sel_full, busy, detect_add,
             lfd_state, ld_state, laf_state, full_state, lp_state,
             rst_int_reg, write_enb_reg
   );
endinterface

// File: rtl/router_ctrl.sv
// rtl/router_ctrl.sv - packet FSM, address latch and per-port read-timeout watchdog
module router_ctrl #(
   parameter int TIMEOUT = 30
) (
   input  logic          clock,
   input  logic          resetn,
   router_ctrl_if.slave  bus
);
   localparam int CW = $clog2(TIMEOUT);

   typedef enum logic [2:0] {
      DECODE_ADDRESS,
      WAIT_TILL_EMPTY,
      LOAD_FIRST_DATA,
      LOAD_DATA,
      FIFO_FULL_STATE,
      LOAD_AFTER_FULL,
      LOAD_PARITY,
      CHECK_PARITY_ERROR
   } state_t;

   state_t        state;
   state_t        next_state;
   logic [1:0]    addr_q;
   logic [CW-1:0] cnt [3];
   logic [2:0]    soft_reset_q;
   logic          port_flush;
   logic          addr_ok;

   // Address 3 has no FIFO behind it, so it selects nothing.
   function automatic logic pick(input logic [2:0] v, input logic [1:0] i);
      case (i)
         2'd0:    pick = v[0];
         2'd1:    pick = v[1];
         2'd2:    pick = v[2];
         default: pick = 1'b0;
      endcase
   endfunction

   assign addr_ok        = bus.packet_valid && (bus.addr_in != 2'd3);
   assign bus.sel_full   = pick(bus.fifo_full, addr_q);
   assign bus.vld_out    = ~bus.fifo_empty;
   assign bus.soft_reset = soft_reset_q;
   assign port_flush     = pick(soft_reset_q, addr_q);

   always_ff @(posedge clock) begin
      if (!resetn) begin
         state  <= DECODE_ADDRESS;
         addr_q <= 2'd0;
      end else begin
         state <= next_state;
         if (state == DECODE_ADDRESS && addr_ok)
            addr_q <= bus.addr_in;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         DECODE_ADDRESS:
            if (addr_ok)
               next_state = pick(bus.fifo_empty, bus.addr_in) ? LOAD_FIRST_DATA
                                                              : WAIT_TILL_EMPTY;
         WAIT_TILL_EMPTY:
            if (pick(bus.fifo_empty, addr_q)) next_state = LOAD_FIRST_DATA;
         LOAD_FIRST_DATA:
            next_state = LOAD_DATA;
         LOAD_DATA:
            if (bus.sel_full)           next_state = FIFO_FULL_STATE;
            else if (!bus.packet_valid) next_state = LOAD_PARITY;
         FIFO_FULL_STATE:
            if (!bus.sel_full) next_state = LOAD_AFTER_FULL;
         LOAD_AFTER_FULL:
            if (bus.parity_done)           next_state = DECODE_ADDRESS;
            else if (bus.low_packet_valid) next_state = LOAD_PARITY;
            else                           next_state = LOAD_DATA;
         LOAD_PARITY:
            next_state = CHECK_PARITY_ERROR;
         CHECK_PARITY_ERROR:
            next_state = bus.sel_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
         default:
            next_state = DECODE_ADDRESS;
      endcase
      // A flush of the FIFO we are writing abandons the packet.
      if (state != DECODE_ADDRESS && port_flush)
         next_state = DECODE_ADDRESS;
   end

   always_comb begin
      bus.detect_add    = 1'b0;
      bus.lfd_state     = 1'b0;
      bus.ld_state      = 1'b0;
      bus.laf_state     = 1'b0;
      bus.full_state    = 1'b0;
      bus.lp_state      = 1'b0;
      bus.rst_int_reg   = 1'b0;
      bus.write_enb_reg = 1'b0;
      bus.busy          = 1'b1;
      bus.write_enb     = 3'b000;
      case (state)
         DECODE_ADDRESS: begin
            bus.detect_add = 1'b1;
            bus.busy       = 1'b0;
         end
         LOAD_FIRST_DATA: begin
            bus.lfd_state     = 1'b1;
            bus.write_enb_reg = 1'b1;
         end
         LOAD_DATA: begin
            bus.ld_state      = 1'b1;
            bus.write_enb_reg = 1'b1;
            bus.busy          = 1'b0;
         end
         LOAD_AFTER_FULL: begin
            bus.laf_state     = 1'b1;
            bus.write_enb_reg = 1'b1;
         end
         FIFO_FULL_STATE:    bus.full_state = 1'b1;
         LOAD_PARITY: begin
            bus.lp_state      = 1'b1;
            bus.write_enb_reg = 1'b1;
         end
         CHECK_PARITY_ERROR: bus.rst_int_reg = 1'b1;
         default: ;
      endcase
      if (bus.write_enb_reg)
         bus.write_enb = 3'b001 << addr_q;
   end

   // A read on the terminal-count cycle clears the counter before it can fire.
   always_ff @(posedge clock) begin
      if (!resetn) begin
         soft_reset_q <= 3'b000;
         for (int k = 0; k < 3; k++) cnt[k] <= '0;
      end else begin
         soft_reset_q <= 3'b000;
         for (int k = 0; k < 3; k++) begin
            if (!bus.vld_out[k] || bus.read_enb[k]) begin
               cnt[k] <= '0;
            end else if (cnt[k] == CW'(TIMEOUT - 1)) begin
               soft_reset_q[k] <= 1'b1;
               cnt[k]          <= '0;
            end else begin
               cnt[k] <= cnt[k] + CW'(1);
            end
         end
      end
   end
endmodule
